// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Stage-register control codes, operand forward selects and the bus-wait FSM state type.
package pipe_ctrl_pkg;

    localparam logic [1:0] CTRL_RUN   = 2'b00;
    localparam logic [1:0] CTRL_HOLD  = 2'b01;
    localparam logic [1:0] CTRL_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FAULT    = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline.
// master: the hazard controller; slave: the pipeline / stage registers.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int NUM_RP = 2
);
    logic [NUM_RP*REG_AW-1:0] id_rs_i;
    logic [NUM_RP-1:0]        id_rs_used_i;
    logic [REG_AW-1:0]        ex_wr_i;
    logic [REG_AW-1:0]        mem_wr_i;
    logic [REG_AW-1:0]        wb_wr_i;
    logic                     ex_rf_we_i;
    logic                     mem_rf_we_i;
    logic                     wb_rf_we_i;
    logic                     ex_is_load_i;
    logic                     mem_bus_req_i;
    logic                     bus_ready_i;
    logic                     branch_taken_i;
    logic [1:0]               if_id_ctrl_o;
    logic [1:0]               id_ex_ctrl_o;
    logic [1:0]               ex_mem_ctrl_o;
    logic [1:0]               mem_wb_ctrl_o;
    logic                     pc_keep_o;
    logic                     pc_redirect_o;
    logic [NUM_RP*2-1:0]      fwd_sel_o;
    logic                     bus_timeout_o;

    modport master (
        input  id_rs_i, id_rs_used_i, ex_wr_i, mem_wr_i, wb_wr_i,
               ex_rf_we_i, mem_rf_we_i, wb_rf_we_i, ex_is_load_i,
               mem_bus_req_i, bus_ready_i, branch_taken_i,
        output if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o,
               pc_keep_o, pc_redirect_o, fwd_sel_o, bus_timeout_o
    );

    modport slave (
        output id_rs_i, id_rs_used_i, ex_wr_i, mem_wr_i, wb_wr_i,
               ex_rf_we_i, mem_rf_we_i, wb_rf_we_i, ex_is_load_i,
               mem_bus_req_i, bus_ready_i, branch_taken_i,
        input  if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o,
               pc_keep_o, pc_redirect_o, fwd_sel_o, bus_timeout_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Per-read-port comparator: flags which later stage will write the register
// this ID read port needs. Register x0 is hardwired and never matches.
module hazard_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    input  logic [REG_AW-1:0] ex_wr,
    input  logic [REG_AW-1:0] mem_wr,
    input  logic [REG_AW-1:0] wb_wr,
    input  logic              ex_we,
    input  logic              mem_we,
    input  logic              wb_we,
    output logic              ex_hit,
    output logic              mem_hit,
    output logic              wb_hit
);
    logic rs_live;

    // rs != 0 together with wr == rs already implies wr != 0
    assign rs_live = used && (rs != '0);
    assign ex_hit  = rs_live && ex_we  && (ex_wr  == rs);
    assign mem_hit = rs_live && mem_we && (mem_wr == rs);
    assign wb_hit  = rs_live && wb_we  && (wb_wr  == rs);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use interlock,
// bus-wait freeze with timeout, and branch flush. Sole source of freeze/flush.
// Optional macro PIPE_PERF_CNT_EN adds stall/flush/wait performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_RP      = 2,
    parameter int FWD_MODE    = 1,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pipe_hazard_ctrl_if.master  bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         flush_events_o,
    output logic [31:0]         wait_cycles_o
`endif
);
    localparam int CW = $clog2(BUS_TIMEOUT) + 1;

    ctrl_state_t       state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              fault_set;
    logic              timeout_flag;
    logic [NUM_RP-1:0] ex_hit, mem_hit, wb_hit;
    logic              load_use, freeze, branch_act, stall_act;
    logic [1:0]        if_id, id_ex, ex_mem, mem_wb;
    logic              pc_keep, pc_redirect;
    logic [NUM_RP*2-1:0] fwd_sel;

    for (genvar p = 0; p < NUM_RP; p++) begin : g_port
        hazard_match #(.REG_AW(REG_AW)) u_match (
            .rs      (bus.id_rs_i[p*REG_AW +: REG_AW]),
            .used    (bus.id_rs_used_i[p]),
            .ex_wr   (bus.ex_wr_i),
            .mem_wr  (bus.mem_wr_i),
            .wb_wr   (bus.wb_wr_i),
            .ex_we   (bus.ex_rf_we_i),
            .mem_we  (bus.mem_rf_we_i),
            .wb_we   (bus.wb_rf_we_i),
            .ex_hit  (ex_hit[p]),
            .mem_hit (mem_hit[p]),
            .wb_hit  (wb_hit[p])
        );
    end

    // Without forwarding any pending writer blocks the read; with it only an EX load does
    assign load_use   = (FWD_MODE != 0) ? ((|ex_hit) && bus.ex_is_load_i)
                                        : (|(ex_hit | mem_hit | wb_hit));
    assign freeze     = ((state == ST_RUN) && bus.mem_bus_req_i && !bus.bus_ready_i) ||
                        ((state == ST_MEM_WAIT) && !bus.bus_ready_i);
    assign branch_act = !freeze && bus.branch_taken_i;
    assign stall_act  = !freeze && !bus.branch_taken_i && load_use;

    // State, wait counter and sticky fault flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_RUN;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fault_set) timeout_flag <= 1'b1;
        end
    end

    // Next state and stage-register control, highest priority first
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fault_set   = 1'b0;
        if_id       = CTRL_RUN;
        id_ex       = CTRL_RUN;
        ex_mem      = CTRL_RUN;
        mem_wb      = CTRL_RUN;
        pc_keep     = 1'b0;
        pc_redirect = 1'b0;
        unique case (state)
            ST_RUN: begin
                // The entry cycle is already the first waited cycle
                if (bus.mem_bus_req_i && !bus.bus_ready_i) begin
                    state_nxt = ST_MEM_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.bus_ready_i) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(BUS_TIMEOUT - 1)) begin
                    state_nxt = ST_FAULT;
                    cnt_nxt   = '0;
                    fault_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_FAULT: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase

        if (!rst_n_i) begin
            if_id   = CTRL_FLUSH;
            id_ex   = CTRL_FLUSH;
            ex_mem  = CTRL_FLUSH;
            mem_wb  = CTRL_FLUSH;
            pc_keep = 1'b1;
        end else if (freeze) begin
            if_id   = CTRL_HOLD;
            id_ex   = CTRL_HOLD;
            ex_mem  = CTRL_HOLD;
            mem_wb  = CTRL_HOLD;
            pc_keep = 1'b1;
        end else begin
            if (branch_act) begin
                if_id       = CTRL_FLUSH;
                id_ex       = CTRL_FLUSH;
                pc_redirect = 1'b1;
            end else if (stall_act) begin
                if_id   = CTRL_HOLD;
                id_ex   = CTRL_FLUSH;
                pc_keep = 1'b1;
            end
            // Timed-out access is dropped rather than written back
            if (state == ST_FAULT) mem_wb = CTRL_FLUSH;
        end
    end

    // Operand source per read port: youngest producer wins
    always_comb begin
        fwd_sel = '0;
        if (rst_n_i && (FWD_MODE != 0)) begin
            for (int p = 0; p < NUM_RP; p++) begin
                if (ex_hit[p])       fwd_sel[p*2 +: 2] = FWD_EX;
                else if (mem_hit[p]) fwd_sel[p*2 +: 2] = FWD_MEM;
                else if (wb_hit[p])  fwd_sel[p*2 +: 2] = FWD_WB;
            end
        end
    end

    assign bus.if_id_ctrl_o  = if_id;
    assign bus.id_ex_ctrl_o  = id_ex;
    assign bus.ex_mem_ctrl_o = ex_mem;
    assign bus.mem_wb_ctrl_o = mem_wb;
    assign bus.pc_keep_o     = pc_keep;
    assign bus.pc_redirect_o = pc_redirect;
    assign bus.fwd_sel_o     = fwd_sel;
    assign bus.bus_timeout_o = timeout_flag;

`ifdef PIPE_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cycles_o <= '0;
            flush_events_o <= '0;
            wait_cycles_o  <= '0;
        end else begin
            if (stall_act)  stall_cycles_o <= stall_cycles_o + 32'd1;
            if (branch_act) flush_events_o <= flush_events_o + 32'd1;
            if (freeze)     wait_cycles_o  <= wait_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FWD_MODE=1, BUS_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int NUM_RP = 2;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .NUM_RP(NUM_RP)) hif ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, wait_cycles;
    logic [31:0] s0, f0, w0;
`endif

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .NUM_RP(NUM_RP), .FWD_MODE(1), .BUS_TIMEOUT(4)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (hif.master)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events),
        .wait_cycles_o  (wait_cycles)
`endif
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] ctrl_all;
    assign ctrl_all = {hif.if_id_ctrl_o, hif.id_ex_ctrl_o, hif.ex_mem_ctrl_o, hif.mem_wb_ctrl_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hif.id_rs_i        = '0;
        hif.id_rs_used_i   = '0;
        hif.ex_wr_i        = '0;
        hif.mem_wr_i       = '0;
        hif.wb_wr_i        = '0;
        hif.ex_rf_we_i     = 1'b0;
        hif.mem_rf_we_i    = 1'b0;
        hif.wb_rf_we_i     = 1'b0;
        hif.ex_is_load_i   = 1'b0;
        hif.mem_bus_req_i  = 1'b0;
        hif.bus_ready_i    = 1'b0;
        hif.branch_taken_i = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] r1, input logic [4:0] r0, input logic [1:0] used);
        hif.id_rs_i      = {r1, r0};
        hif.id_rs_used_i = used;
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Check comb outputs mid-cycle, away from the active edge
    task automatic look(input string tag, input logic [7:0] ctrl, input logic keep,
                        input logic redir, input logic [3:0] fwd);
        @(negedge clk_i);
        chk({tag, "_ctrl"}, ctrl_all, ctrl);
        chk({tag, "_keep"}, hif.pc_keep_o, keep);
        chk({tag, "_redir"}, hif.pc_redirect_o, redir);
        chk({tag, "_fwd"}, hif.fwd_sel_o, fwd);
    endtask

    initial begin
        idle();
        set_rs(5'd2, 5'd1, 2'b11);
        // Reset: all stages flushed, PC held
        look("rst", 8'hAA, 1'b1, 1'b0, 4'h0);
        chk("rst_tmo", hif.bus_timeout_o, 1'b0);
        cyc();
        rst_n_i = 1'b1;

        // No hazards
        look("nohaz", 8'h00, 1'b0, 1'b0, 4'h0);
        cyc();

        // EX non-load writes x5, port 0 reads x5 -> forward EX
        hif.ex_wr_i = 5'd5; hif.ex_rf_we_i = 1'b1;
        set_rs(5'd2, 5'd5, 2'b11);
        look("fwd_ex", 8'h00, 1'b0, 1'b0, 4'b0001);
        cyc();
        // EX and MEM both write x5 -> EX still wins
        hif.mem_wr_i = 5'd5; hif.mem_rf_we_i = 1'b1;
        look("fwd_exmem", 8'h00, 1'b0, 1'b0, 4'b0001);
        cyc();
        // port0 from WB, port1 from MEM
        idle();
        hif.mem_wr_i = 5'd3; hif.mem_rf_we_i = 1'b1;
        hif.wb_wr_i  = 5'd4; hif.wb_rf_we_i  = 1'b1;
        set_rs(5'd3, 5'd4, 2'b11);
        look("fwd_memwb", 8'h00, 1'b0, 1'b0, 4'b1011);
        cyc();

`ifdef PIPE_PERF_CNT_EN
        s0 = stall_cycles;
`endif
        // Load-use: EX load to x7, port1 reads x7 -> one stall cycle
        idle();
        hif.ex_wr_i = 5'd7; hif.ex_rf_we_i = 1'b1; hif.ex_is_load_i = 1'b1;
        set_rs(5'd7, 5'd1, 2'b11);
        look("lduse", 8'h60, 1'b1, 1'b0, 4'b0100);
        cyc();
        // Load moved to MEM -> forward MEM, no stall
        hif.ex_rf_we_i = 1'b0; hif.ex_is_load_i = 1'b0;
        hif.mem_wr_i = 5'd7; hif.mem_rf_we_i = 1'b1;
        look("lduse_next", 8'h00, 1'b0, 1'b0, 4'b1000);
        cyc();
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall", stall_cycles - s0, 32'd1);
`endif
        // x0 never matches
        idle();
        hif.ex_wr_i = 5'd0; hif.ex_rf_we_i = 1'b1; hif.ex_is_load_i = 1'b1;
        set_rs(5'd0, 5'd0, 2'b11);
        look("x0", 8'h00, 1'b0, 1'b0, 4'h0);
        cyc();
        // Unused source does not stall
        hif.ex_wr_i = 5'd7;
        set_rs(5'd7, 5'd7, 2'b00);
        look("unused", 8'h00, 1'b0, 1'b0, 4'h0);
        cyc();
        // Branch beats load-use
        set_rs(5'd7, 5'd1, 2'b11);
        hif.branch_taken_i = 1'b1;
        look("br_over_ld", 8'hA0, 1'b0, 1'b1, 4'b0100);
        cyc();

`ifdef PIPE_PERF_CNT_EN
        w0 = wait_cycles;
        f0 = flush_events;
`endif
        // Bus wait: ready low 3 cycles (branch pending), high on the 4th
        idle();
        hif.mem_bus_req_i = 1'b1; hif.branch_taken_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("wait%0d", i), 8'h55, 1'b1, 1'b0, 4'h0);
            cyc();
        end
        // 4th cycle coincides with the timeout count: ready wins
        hif.bus_ready_i = 1'b1;
        look("wait_rdy", 8'hA0, 1'b0, 1'b1, 4'h0);
        cyc();
        idle();
        look("wait_after", 8'h00, 1'b0, 1'b0, 4'h0);
        chk("wait_notmo", hif.bus_timeout_o, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_wait", wait_cycles - w0, 32'd3);
        chk("perf_flush", flush_events - f0, 32'd1);
`endif
        cyc();

        // Timeout: ready never comes -> 4 freeze cycles then FAULT
        hif.mem_bus_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look($sformatf("tmo_frz%0d", i), 8'h55, 1'b1, 1'b0, 4'h0);
            cyc();
        end
        hif.mem_bus_req_i = 1'b0;
        look("fault", 8'h02, 1'b0, 1'b0, 4'h0);
        chk("fault_tmo", hif.bus_timeout_o, 1'b1);
        cyc();
        look("post_fault", 8'h00, 1'b0, 1'b0, 4'h0);
        chk("tmo_sticky", hif.bus_timeout_o, 1'b1);
        cyc();

        // Reset in the middle of a wait
        hif.mem_bus_req_i = 1'b1;
        cyc();
        cyc();
        rst_n_i = 1'b0;
        #1;
        chk("midrst_ctrl", ctrl_all, 8'hAA);
        chk("midrst_keep", hif.pc_keep_o, 1'b1);
        chk("midrst_tmo", hif.bus_timeout_o, 1'b0);
        cyc();
        rst_n_i = 1'b1;
        idle();
        look("midrst_run", 8'h00, 1'b0, 1'b0, 4'h0);
        cyc();
        // Counter restarted: a fresh wait again takes 4 freeze cycles to fault
        hif.mem_bus_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look($sformatf("re_frz%0d", i), 8'h55, 1'b1, 1'b0, 4'h0);
            cyc();
        end
        hif.mem_bus_req_i = 1'b0;
        look("re_fault", 8'h02, 1'b0, 1'b0, 4'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised next-generation pipeline controller for the 5-stage core.
- Drives the 2-bit data_ctrl of IF_ID, ID_EX, EX_MEM and MEM_WB, plus PC keep/redirect.
- Adds three things: EX/MEM/WB operand forwarding selects, load-use interlock, and a multi-cycle bus-wait FSM with timeout.
- Sits beside IFETCH and the stage registers; it is the only source of freeze and flush in the pipeline.

Parameters:
- REG_AW, 5: register index width.
- NUM_RP, 2: ID read ports checked for hazards.
- FWD_MODE, 1: 0 = stall-only interlock; 1 = forwarding plus load-use stall.
- BUS_TIMEOUT, 16: maximum MEM_WAIT cycles before fault (≥2).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- id_rs_i  in  NUM_RP*REG_AW  ID source register indices, port 0 in the LSBs
- id_rs_used_i  in  NUM_RP  source actually read
- ex_wr_i, mem_wr_i, wb_wr_i  in  REG_AW each  destination index per stage
- ex_rf_we_i, mem_rf_we_i, wb_rf_we_i  in  1 each  stage writes the register file
- ex_is_load_i  in  1  EX instruction is a load
- mem_bus_req_i  in  1  MEM stage is accessing the bus
- bus_ready_i  in  1  bus access completes this cycle
- branch_taken_i  in  1  EX resolved a redirect
- if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o  out  2 each  stage-register control
- pc_keep_o  out  1  PC holds
- pc_redirect_o  out  1  PC loads the branch target
- fwd_sel_o  out  NUM_RP*2  per-port operand source
- bus_timeout_o  out  1  sticky bus fault flag

Behaviour:
- Ctrl encoding: 00 RUN (load), 01 HOLD, 10 FLUSH (load bubble), 11 reserved (treated as HOLD by stage registers).
- Forward-select encoding: 00 register file, 01 EX, 10 MEM, 11 WB.
- Reset (rst_n_i low, asynchronous):
  - state=RUN, wait counter=0, bus_timeout_o=0.
  - All ctrl outputs forced to FLUSH; pc_keep_o=1; pc_redirect_o=0; fwd_sel_o=0.
- Match definition: port p matches stage S when id_rs_used_i[p], S_rf_we_i, S_wr_i==id_rs[p], and S_wr_i!=0. Register x0 never matches.
- FSM states: RUN, MEM_WAIT, FAULT. The counter is active only in MEM_WAIT.
  - RUN -> MEM_WAIT when mem_bus_req_i && !bus_ready_i. Freeze is asserted in that same cycle.
  - MEM_WAIT: counter +1 per cycle.
    - bus_ready_i -> RUN; no freeze in that cycle; counter cleared.
    - counter==BUS_TIMEOUT-1 without ready -> FAULT.
  - FAULT (one cycle): mem_wb_ctrl_o=FLUSH (access dropped), other stages RUN, bus_timeout_o set sticky until reset, -> RUN.
  - bus_ready_i arriving in the same cycle as the timeout: ready wins, go to RUN, no fault.
- Priority, highest first (evaluated combinationally each cycle):
  1. Freeze (RUN with stall condition, or MEM_WAIT without ready): all four ctrl=HOLD, pc_keep_o=1, pc_redirect_o=0. Branch_taken_i persists because EX is held and is applied when the freeze ends.
  2. Branch: if_id=FLUSH, id_ex=FLUSH, pc_redirect_o=1, pc_keep_o=0. Overrides load-use stall.
  3. Load-use stall:
     - FWD_MODE=1: any port matches EX && ex_is_load_i.
     - FWD_MODE=0: any port matches EX, MEM or WB.
     - Action: if_id=HOLD, id_ex=FLUSH, pc_keep_o=1, others RUN.
  4. Otherwise: all RUN, pc_keep_o=0.
- fwd_sel_o:
  - FWD_MODE=0: always 00.
  - FWD_MODE=1: per port, first match in order EX(01), MEM(10), WB(11), else 00. Computed regardless of stall.
  - For MEM forwarding of a load, the datapath chooses rdata; that choice is outside this block.
- Load-use stall is self-limiting: exactly 1 cycle in FWD_MODE=1, at most 3 cycles in FWD_MODE=0.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cycles_o, flush_events_o, wait_cycles_o.
  - stall_cycles_o: +1 per load-use stall cycle.
  - flush_events_o: +1 per branch flush.
  - wait_cycles_o: +1 per freeze cycle.
  - All wrap at 2^32 and are reset to 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - CTRL_RUN/HOLD/FLUSH constants.
  - FWD_RF/EX/MEM/WB constants.
  - FSM state typedef.
- One sub-module, hazard_match: combinational per-port comparator producing ex/mem/wb match bits. Instantiated NUM_RP times.

Test Plan:
- Reset release, no hazards: rs=(1,2), no writers -> all ctrl 00, pc_keep 0, fwd_sel 0.
- FWD_MODE=1, EX writes x5 with non-load, id_rs0=5: fwd_sel[1:0]=01, no stall. Same case with EX and MEM both writing x5: result still 01.
- FWD_MODE=1, EX load to x7, id_rs1=7: one cycle with if_id=01, id_ex=10, pc_keep=1; next cycle fwd_sel[3:2]=10 and no stall. id_rs=0 with EX writing x0 -> no stall.
- Bus wait: mem_bus_req=1, ready low 3 cycles then high -> 3 freeze cycles, all ctrl=01; RUN on the ready cycle. branch_taken held through the freeze -> redirect and flush once, on the ready cycle.
- Timeout with BUS_TIMEOUT=4, ready never asserted -> freeze 4 cycles, then FAULT with mem_wb=10, bus_timeout_o=1 sticky. Ready asserted on the timeout cycle -> no fault.
- Mid-wait reset: assert rst_n_i low in MEM_WAIT -> immediate FLUSH outputs, state RUN, counter 0, flag cleared. With PIPE_PERF_CNT_EN, scenarios 3 and 4 give stall_cycles=1 and wait_cycles=3.
